orth_dds: RTL and testbench
===========================

Name: orth_dds

Overview:
- Orthogonal (quadrature) direct digital synthesiser: phase accumulator plus quarter-wave sine lookup. Produces signed sine and cosine samples.
- Used as a stimulus/test-tone source feeding streaming DSP blocks such as FIR filters.
- Advances one sample per enabled clock.

Parameters:
- PW, 32, width of frequency control word, phase offset and phase accumulator.
- DW, 12, width of the signed sin/cos output samples.
- AW, 13, phase resolution in bits after truncation; the full-wave table has 2^AW points; the stored quarter table has 2^(AW-2) entries.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst_n  in  1  reset, active-low.
- en  in  1  sample enable; when low, all state holds.
- freq  in  PW  signed frequency control word; f_out = freq/2^PW * f_clk.
- phase  in  PW  phase offset added after the accumulator; 2^PW equals one full turn.
- sin  out  DW  signed sine sample.
- cos  out  DW  signed cosine sample; may be left unconnected.

Behaviour:
- Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- Reset:
  - While rst_n=0, the following clear immediately, independent of clk: acc=0, p1=0, sin=0, cos=0.
  - Reset asserted mid-operation clears immediately; the first enabled edge after release restarts from acc=0.
- Per rising edge with en=1, all updates are simultaneous:
  - acc <= acc + freq, modulo 2^PW, wrapping silently.
  - p1 <= acc + phase, using the old acc, modulo 2^PW.
  - sin/cos are registered from p1 through the lookup below.
- en=0: acc, p1, sin and cos all hold.
- Latency:
  - The n-th enabled edge (n>=2) outputs sin = S(phase + (n-2)*freq) and cos = C(...) of the same phase.
  - The first enabled edge outputs table values for p1=0, i.e. S(0).
- Lookup:
  - a = p1[PW-1 -: AW] (truncation, no dither).
  - q = a[AW-1:AW-2] is the quadrant; i = a[AW-3:0] is the index.
- Quarter table:
  - T[k] = round((2^(DW-1)-1) * sin(2*pi*(k+0.5)/2^AW)) for k = 0..2^(AW-2)-1.
  - Computed at elaboration by a real-valued constant function; no external file.
  - Every entry lies in 0..2^(DW-1)-1, so negation never overflows.
- Sine S, by quadrant:
  - q=0: +T[i]
  - q=1: +T[~i]
  - q=2: -T[i]
  - q=3: -T[~i]
- Cosine C uses the same rule with quadrant q+1 (mod 4) and the same i, i.e. a quarter-turn lead.
- Symmetry: S(p+half turn) = -S(p) exactly, and the output is never the most-negative code.
- freq is treated as an unsigned bit pattern in the adder; negative values produce negative frequency via wrap.
- freq and phase may change on any edge; the new value takes effect on that enabled edge.

Test Plan:
- Reset then en=1, freq=0, phase=0:
  - First enabled edge: sin=T[0]=1, cos=T[2^(AW-2)-1]=2047.
  - Outputs constant thereafter.
  - sin=cos=0 while rst_n=0.
- freq=0, phase=32'h4000_0000:
  - From the second enabled edge: sin=2047, cos=-1.
  - phase=32'h8000_0000 gives sin=-1, cos=-2047.
- freq=32'h2000_0000, phase=0:
  - Period of 8 samples; sin[k+4] = -sin[k], cos[k] = sin[k+2].
  - Sequence starts 1, T[1024], 2047, T[1023]...
- en toggling 1,0,0,1 with freq=32'h2000_0000:
  - Outputs hold during en=0.
  - Sequence resumes without skipped samples.
- Accumulator wrap, freq=32'hFFFF_FFFF (-1):
  - acc counts down through 0 to 2^32-1.
  - sin follows the mirrored (negative-frequency) sequence, no glitch at wrap.
- Reset mid-run:
  - Assert rst_n=0 between edges; outputs go to 0 immediately (async).
  - After release, the sequence restarts as in the first scenario.
- Full sweep, freq from 1% to 50% of f_clk:
  - |sin| <= 2047 always.
  - sin^2 + cos^2 stays within 2047^2 ± 2*2047+2 (quadrature magnitude check).

Source files
------------

// File: rtl/orth_dds.sv
// orth_dds: quadrature DDS, phase accumulator driving a quarter-wave sine/cosine lookup.
module orth_dds #(
  parameter int PW = 32,
  parameter int DW = 12,
  parameter int AW = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [PW-1:0]        freq,
  input  logic [PW-1:0]        phase,
  output logic signed [DW-1:0] sin,
  output logic signed [DW-1:0] cos
);
  localparam int Q = 1 << (AW - 2);
  localparam real PI = 3.14159265358979323846;
  function automatic real qsin(input real x);
    real t, s;
    t = x;
    s = x;
    for (int n = 1; n < 12; n++) begin
      t = -t * x * x / real'((2 * n) * (2 * n + 1));
      s = s + t;
    end
    return s;
  endfunction
  // half-index offset keeps every entry strictly positive and mirror-exact across quadrants
  function automatic logic [DW-2:0] tval(input int k);
    return (DW-1)'($rtoi(qsin(PI * real'(2 * k + 1) / real'(1 << AW)) * real'((1 << (DW - 1)) - 1) + 0.5));
  endfunction
  logic [DW-2:0] tbl [Q];
  for (genvar k = 0; k < Q; k++) begin : g_t
    localparam logic [DW-2:0] V = tval(k);
    assign tbl[k] = V;
  end
  logic [PW-1:0] acc_q, acc_d, p1_q, p1_d;
  logic signed [DW-1:0] sin_q, sin_d, cos_q, cos_d;
  logic [AW-1:0] a;
  logic [PW-AW-1:0] frac_unused;
  logic [1:0] qs, qc;
  logic [AW-3:0] i, s_idx, c_idx;
  logic [DW-1:0] s_mag, c_mag;
  assign {a, frac_unused} = p1_q;
  assign qs = a[AW-1:AW-2];
  assign qc = qs + 2'd1;
  assign i = a[AW-3:0];
  always_comb begin
    acc_d = acc_q + freq;
    p1_d = acc_q + phase;
    s_idx = qs[0] ? ~i : i;
    c_idx = qc[0] ? ~i : i;
    s_mag = {1'b0, tbl[s_idx]};
    c_mag = {1'b0, tbl[c_idx]};
    sin_d = qs[1] ? -s_mag : s_mag;
    cos_d = qc[1] ? -c_mag : c_mag;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      p1_q <= '0;
      sin_q <= '0;
      cos_q <= '0;
    end else if (en) begin
      acc_q <= acc_d;
      p1_q <= p1_d;
      sin_q <= sin_d;
      cos_q <= cos_d;
    end
  end
  assign sin = sin_q;
  assign cos = cos_q;
endmodule

// File: tb/tb_orth_dds.sv
// tb_orth_dds: directed scoreboard bench for orth_dds.
module tb_orth_dds;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [31:0] freq = '0;
  logic [31:0] phase = '0;
  logic signed [11:0] s_o, c_o;
  int pass_n = 0;
  int total_n = 0;
  int mq[$];
  int sq[$];
  int cq[$];
  string nq[$];
  orth_dds #(.PW(32), .DW(12), .AW(13)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .freq(freq), .phase(phase), .sin(s_o), .cos(c_o)
  );
  always #5 clk = ~clk;
  task automatic cmp(input string nm, input int as, input int ac, input int es, input int ec);
    total_n++;
    if (as != es || ac != ec)
      $display("FAIL %s: got sin=%0d cos=%0d, expected sin=%0d cos=%0d", nm, as, ac, es, ec);
    else
      pass_n++;
  endtask
  task automatic cmp_mag(input string nm, input int as, input int ac);
    int m;
    m = as * as + ac * ac;
    total_n++;
    if (as < -2047 || as > 2047 || ac < -2047 || ac > 2047 ||
        m < 2047 * 2047 - 2 * 2047 - 2 || m > 2047 * 2047 + 2 * 2047 + 2)
      $display("FAIL %s: got sin=%0d cos=%0d (sin^2+cos^2=%0d), expected |x|<=2047 and magnitude within 2047^2+-4096", nm, as, ac, m);
    else
      pass_n++;
  endtask
  // monitor: one scoreboard entry per driven edge; mode 0 skip, 1 exact, 2 magnitude
  initial forever begin
    @(posedge clk);
    #1;
    if (mq.size() > 0) begin
      int m, es, ec;
      string nm;
      m = mq.pop_front();
      es = sq.pop_front();
      ec = cq.pop_front();
      nm = nq.pop_front();
      if (m == 1) cmp(nm, int'(s_o), int'(c_o), es, ec);
      else if (m == 2) cmp_mag(nm, int'(s_o), int'(c_o));
    end
  end
  task automatic step(input logic e, input logic [31:0] f, input logic [31:0] p, input int m,
                      input int es, input int ec, input string nm);
    en = e;
    freq = f;
    phase = p;
    mq.push_back(m);
    sq.push_back(es);
    cq.push_back(ec);
    nq.push_back(nm);
    @(posedge clk);
    #2;
  endtask
  task automatic mid_reset(input string nm);
    rst_n = 1'b0;
    #1;
    cmp(nm, int'(s_o), int'(c_o), 0, 0);
    #3;
    rst_n = 1'b1;
  endtask
  localparam int SW_N = 7;
  logic [31:0] sweep [SW_N] = '{32'h028F5C29, 32'h11EB851F, 32'h2147AE14, 32'h40000000,
                                 32'h547AE148, 32'h68F5C28F, 32'h80000000};
  initial begin
    #3;
    cmp("reset_async", int'(s_o), int'(c_o), 0, 0);
    en = 1'b1;
    freq = 32'h2000_0000;
    @(posedge clk);
    @(posedge clk);
    #2;
    cmp("reset_held_clocked", int'(s_o), int'(c_o), 0, 0);
    rst_n = 1'b1;
    step(1, 32'h0, 32'h0, 1, 1, 2047, "dc_first");
    step(1, 32'h0, 32'h0, 1, 1, 2047, "dc_hold1");
    step(1, 32'h0, 32'h0, 1, 1, 2047, "dc_hold2");
    step(1, 32'h0, 32'h4000_0000, 1, 1, 2047, "ph90_lat");
    step(1, 32'h0, 32'h4000_0000, 1, 2047, -1, "ph90_a");
    step(1, 32'h0, 32'h4000_0000, 1, 2047, -1, "ph90_b");
    step(1, 32'h0, 32'h8000_0000, 1, 2047, -1, "ph180_lat");
    step(1, 32'h0, 32'h8000_0000, 1, -1, -2047, "ph180_a");
    step(1, 32'h0, 32'h8000_0000, 1, -1, -2047, "ph180_b");
    mid_reset("reset_mid");
    step(1, 32'h2000_0000, 32'h0, 1, 1, 2047, "f8_0");
    step(1, 32'h2000_0000, 32'h0, 1, 1, 2047, "f8_1");
    step(1, 32'h2000_0000, 32'h0, 1, 1448, 1447, "f8_2");
    step(1, 32'h2000_0000, 32'h0, 1, 2047, -1, "f8_3");
    step(0, 32'h2000_0000, 32'h0, 1, 2047, -1, "en_hold1");
    step(0, 32'h2000_0000, 32'h0, 1, 2047, -1, "en_hold2");
    step(1, 32'h2000_0000, 32'h0, 1, 1447, -1448, "f8_4");
    step(1, 32'h2000_0000, 32'h0, 1, -1, -2047, "f8_5");
    step(1, 32'h2000_0000, 32'h0, 1, -1448, -1447, "f8_6");
    step(1, 32'h2000_0000, 32'h0, 1, -2047, 1, "f8_7");
    step(1, 32'h2000_0000, 32'h0, 1, -1447, 1448, "f8_8");
    step(1, 32'h2000_0000, 32'h0, 1, 1, 2047, "f8_wrap");
    mid_reset("reset_mid2");
    step(1, 32'hFFFF_FFFF, 32'h0, 1, 1, 2047, "neg1_0");
    step(1, 32'hFFFF_FFFF, 32'h0, 1, 1, 2047, "neg1_1");
    step(1, 32'hFFFF_FFFF, 32'h0, 1, -1, 2047, "neg1_wrap");
    step(1, 32'hFFFF_FFFF, 32'h0, 1, -1, 2047, "neg1_3");
    mid_reset("reset_mid3");
    step(1, 32'hE000_0000, 32'h0, 1, 1, 2047, "negf8_0");
    step(1, 32'hE000_0000, 32'h0, 1, 1, 2047, "negf8_1");
    step(1, 32'hE000_0000, 32'h0, 1, -1447, 1448, "negf8_2");
    step(1, 32'hE000_0000, 32'h0, 1, -2047, 1, "negf8_3");
    step(1, 32'hE000_0000, 32'h0, 1, -1448, -1447, "negf8_4");
    step(1, 32'hE000_0000, 32'h0, 1, -1, -2047, "negf8_5");
    for (int k = 0; k < SW_N; k++)
      for (int n = 0; n < 16; n++)
        step(1, sweep[k], 32'h0, 2, 0, 0, $sformatf("sweep_%0d_%0d", k, n));
    repeat (2) @(posedge clk);
    #3;
    if (mq.size() != 0) begin
      total_n++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", mq.size());
    end
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
